// File: rtl/npu_act_pkg.sv
// Shared defaults and types for the NPU activation-memory write arbiter.
package npu_act_pkg;

    localparam int NUM_REQ_DEF   = 32;
    localparam int ADDR_W_DEF    = 12;
    localparam int DATA_W_DEF    = 16;
    localparam int RGB_W_DEF     = 8;
    localparam int RGB_SHIFT_DEF = 5;

    typedef enum logic {
        ARB_RR    = 1'b0,
        ARB_FIXED = 1'b1
    } arb_mode_e;

    // Index width that stays legal for a requester count of one.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/npu_rr_arbiter.sv
// Combinational round-robin / fixed-priority arbiter producing a one-hot grant and its index.
module npu_rr_arbiter
    import npu_act_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    localparam int IDX_W  = idx_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic               mode,
    input  logic [IDX_W-1:0]   pointer,
    input  logic               enable,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   index
);

    logic             found;
    logic [IDX_W:0]   sum;
    logic [IDX_W-1:0] cand;

    always_comb begin
        grant = '0;
        index = '0;
        found = 1'b0;
        sum   = '0;
        cand  = '0;
        if (enable) begin
            if (mode == ARB_FIXED) begin
                for (int i = 0; i < NUM_REQ; i++) begin
                    if (!found && req[i]) begin
                        found = 1'b1;
                        index = IDX_W'(i);
                    end
                end
            end else begin
                // Search starts one past the previous winner and wraps.
                for (int k = 1; k <= NUM_REQ; k++) begin
                    sum = {1'b0, pointer} + (IDX_W+1)'(k);
                    if (sum >= (IDX_W+1)'(NUM_REQ)) begin
                        sum = sum - (IDX_W+1)'(NUM_REQ);
                    end
                    cand = sum[IDX_W-1:0];
                    if (!found && req[cand]) begin
                        found = 1'b1;
                        index = cand;
                    end
                end
            end
            if (found) begin
                grant[index] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/npu_act_mem_arb.sv
// Activation-memory write arbiter with a registered write port and a two-stage read-source mux.
module npu_act_mem_arb
    import npu_act_pkg::*;
#(
    parameter int NUM_REQ   = NUM_REQ_DEF,
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int RGB_W     = RGB_W_DEF,
    parameter int RGB_SHIFT = RGB_SHIFT_DEF
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_wr,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ack,
    input  logic                      arb_mode,
    output logic                      mem_wr_en,
    output logic [ADDR_W-1:0]         mem_wr_addr,
    output logic [DATA_W-1:0]         mem_wr_data,
    input  logic                      mem_wr_ready,
    output logic [15:0]               wr_count,
    input  logic                      rgb_rd,
    input  logic                      act_rd,
    input  logic                      rd_bypass,
    input  logic [RGB_W-1:0]          rgb_rdata,
    input  logic [DATA_W-1:0]         act_rdata,
    input  logic                      test_mode,
    input  logic [DATA_W-1:0]         test_rdata,
    output logic [DATA_W-1:0]         rd_data
);

    localparam int IDX_W = idx_w(NUM_REQ);

    logic                 en_q, en_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic [DATA_W-1:0]    data_q, data_d;
    logic [IDX_W-1:0]     last_q, last_d;
    logic [15:0]          cnt_q, cnt_d;
    logic                 rgb_r1_q, act_r1_q, byp_r1_q;
    logic [DATA_W-1:0]    rd_q, rd_d;

    logic                 load;
    logic [NUM_REQ-1:0]   grant;
    logic [IDX_W-1:0]     grant_idx;
    logic [ADDR_W-1:0]    win_addr;
    logic [DATA_W-1:0]    win_data;
    logic [DATA_W-1:0]    rgb_ext;

    assign load = !en_q || mem_wr_ready;

    npu_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req     (req_wr),
        .mode    (arb_mode),
        .pointer (last_q),
        .enable  (load && !reset),
        .grant   (grant),
        .index   (grant_idx)
    );

    assign req_ack = grant;

    always_comb begin
        win_addr = '0;
        win_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                win_addr = req_addr[i*ADDR_W +: ADDR_W];
                win_data = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    assign rgb_ext = DATA_W'(rgb_rdata) << RGB_SHIFT;

    always_comb begin
        en_d   = en_q;
        addr_d = addr_q;
        data_d = data_q;
        last_d = last_q;
        cnt_d  = cnt_q;
        rd_d   = act_rdata;
        if (load) begin
            if (|grant) begin
                en_d   = 1'b1;
                addr_d = win_addr;
                data_d = win_data;
                last_d = grant_idx;
            end else begin
                en_d = 1'b0;
            end
        end
        if (en_q && mem_wr_ready && (cnt_q != 16'hFFFF)) begin
            cnt_d = cnt_q + 16'd1;
        end
        // act_rdata is both the explicit activation source and the idle default.
        if (byp_r1_q) begin
            rd_d = '0;
        end else if (rgb_r1_q) begin
            rd_d = test_mode ? test_rdata : rgb_ext;
        end else if (act_r1_q) begin
            rd_d = act_rdata;
        end else begin
            rd_d = act_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            en_q     <= 1'b0;
            addr_q   <= '0;
            data_q   <= '0;
            last_q   <= IDX_W'(NUM_REQ-1);
            cnt_q    <= '0;
            rgb_r1_q <= 1'b0;
            act_r1_q <= 1'b0;
            byp_r1_q <= 1'b0;
            rd_q     <= '0;
        end else begin
            en_q     <= en_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            last_q   <= last_d;
            cnt_q    <= cnt_d;
            rgb_r1_q <= rgb_rd;
            act_r1_q <= act_rd;
            byp_r1_q <= rd_bypass;
            rd_q     <= rd_d;
        end
    end

    assign mem_wr_en   = en_q;
    assign mem_wr_addr = addr_q;
    assign mem_wr_data = data_q;
    assign wr_count    = cnt_q;
    assign rd_data     = rd_q;

endmodule
